inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the main memory model: owns the PC, drives the memory address/read_write pins, and captures the combinational read data.
- Buffers fetched words in a 2-entry queue and hands {pc, inst} to decode over a valid/ready handshake.
- Supports branch/jump redirect with queue flush; sticky fault on misaligned or out-of-range PC.

Parameters:
- STARTING_ADDR, 'h01000000, reset PC and base address of the memory window.
- MEM_DEPTH_BYTES, 'h0100000, size of the valid fetch window in bytes.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- mem_address  out  32  fetch address to main memory; equals the PC register.
- mem_read_write  out  1  constant 0 (READ).
- mem_data_in  out  32  constant 0.
- mem_data_out  in  32  instruction word for mem_address; combinational, same cycle.
- redirect_valid  in  1  flush the queue and load redirect_target into PC.
- redirect_target  in  32  new PC.
- inst_valid  out  1  queue head valid.
- inst  out  32  queue head instruction; 0 when empty.
- inst_pc  out  32  queue head PC; 0 when empty.
- inst_ready  in  1  decode accepts head this cycle.
- fault  out  1  sticky fetch fault.
- fault_pc  out  32  PC that caused the fault.

Behaviour:
- Reset (sync, high): pc=STARTING_ADDR, count=0, state=RUN, fault=0, fault_pc=0, inst_valid=0, inst=0, inst_pc=0.
- States:
  - RUN: normal fetch.
  - FAULT: entered when a fetch attempt sees pc[1:0]!=0, pc<STARTING_ADDR, or pc>=STARTING_ADDR+MEM_DEPTH_BYTES.
  - FAULT exits only on reset.
  - On FAULT entry: set fault=1, fault_pc=pc; nothing is pushed.
- fetch_en = (state==RUN) && !redirect_valid && pc legal && (count<2 || (count==2 && inst_ready)).
- On fetch_en at posedge:
  - push {pc, mem_data_out} at the queue tail.
  - pc <= pc+4, 32-bit modulo wrap. Out-of-range is then caught on the next fetch attempt.
- pop = inst_valid && inst_ready && !redirect_valid. Pop removes the head.
  - Push and pop in the same cycle leave count unchanged, order preserved.
- Queue: 2 entries, FIFO order. inst_valid = (count!=0).
  - Head outputs are registered, zero when empty.
- Latency: memory read is same-cycle.
  - Fetch of address A at edge N gives inst_valid with inst_pc=A after edge N.
  - Steady state with inst_ready=1: one instruction per cycle, consecutive PCs +4.
- Backpressure: inst_ready=0 with count==2 stalls the PC. mem_address holds its value until a slot frees.
- redirect_valid (RUN state, highest priority):
  - count<=0, pc<=redirect_target. No push and no pop that cycle.
  - The next cycle fetches the target, or faults if the target is illegal.
- redirect_valid in FAULT: ignored.
  - Queue entries present at fault entry still drain to decode normally.
- Simultaneous reset and redirect: reset wins.
- mem_read_write is never driven to WRITE.

Optional Feature:
- Macro: FETCH_TRACE_EN.
- Defined: on every push, $display "time=%t, address=%8h, data_out=%8h" with $time, the pushed pc, and the pushed instruction. On FAULT entry, one extra line "FETCH FAULT pc=%8h".
- Undefined: no display statements. Cycle behaviour identical.

Test Plan:
- Reset then inst_ready=1 for 4 cycles, memory preloaded with words W0..W3 -> inst_pc sequence 01000000, 01000004, 01000008, 0100000C with matching W0..W3; inst_valid high from the first edge after the fetch of 01000000.
- inst_ready=0 for 5 cycles after reset -> count saturates at 2, mem_address holds 01000008, inst_pc stays 01000000; raise inst_ready -> 01000000, 01000004, 01000008 delivered in order, none dropped or duplicated.
- redirect_valid=1 with target 01000040 while count==2 -> next cycle inst_valid=0, mem_address=01000040; following cycle inst_pc=01000040.
- Redirect to 01000042 -> fault=1, fault_pc=01000042, inst_valid stays 0; later redirect to 01000000 ignored; reset clears fault.
- Sequential run to 010FFFFC then one more fetch -> word at 010FFFFC delivered; fault=1, fault_pc=01100000.
- Reset asserted with count==2 and a pending redirect -> all outputs return to reset values; pc=01000000 the next cycle.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module   : inst_fetch_unit
// Brief    : PC owner and fetch stage with 2-entry queue, redirect and sticky fault.
//            Optional FETCH_TRACE_EN macro enables per-push and fault trace output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_unit #(
    parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
    parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam logic [0:0]  c_RUN      = 1'b0;
    localparam logic [0:0]  c_FAULT    = 1'b1;
    localparam logic [31:0] c_END_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [31:0] r_pc;
    logic [1:0]  r_count;
    logic [31:0] r_head_pc;
    logic [31:0] r_head_inst;
    logic [31:0] r_tail_pc;
    logic [31:0] r_tail_inst;
    logic        r_fault;
    logic [31:0] r_fault_pc;

    logic        w_pc_legal;
    logic        w_fetch_en;
    logic        w_fault_entry;
    logic        w_pop;

    assign w_pc_legal = (r_pc[1:0] == 2'b00) && (r_pc >= STARTING_ADDR) && (r_pc < c_END_ADDR);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == c_RUN && w_fault_entry) begin
            w_state_next = c_FAULT;
        end
    end

    always_comb begin
        w_fetch_en    = 1'b0;
        w_fault_entry = 1'b0;
        if (r_state == c_RUN && !redirect_valid) begin
            if (w_pc_legal) begin
                w_fetch_en = (r_count < 2'd2) || (r_count == 2'd2 && inst_ready);
            end else begin
                w_fault_entry = 1'b1;
            end
        end
        w_pop = (r_count != 2'd0) && inst_ready && !redirect_valid;
    end

    // Tail slot is kept zero unless two entries are held, so a pop shifts zeros into an emptied head.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc        <= STARTING_ADDR;
            r_count     <= 2'd0;
            r_head_pc   <= 32'd0;
            r_head_inst <= 32'd0;
            r_tail_pc   <= 32'd0;
            r_tail_inst <= 32'd0;
            r_fault     <= 1'b0;
            r_fault_pc  <= 32'd0;
        end else begin
            if (w_fault_entry) begin
                r_fault    <= 1'b1;
                r_fault_pc <= r_pc;
            end
            if (r_state == c_RUN && redirect_valid) begin
                r_pc        <= redirect_target;
                r_count     <= 2'd0;
                r_head_pc   <= 32'd0;
                r_head_inst <= 32'd0;
                r_tail_pc   <= 32'd0;
                r_tail_inst <= 32'd0;
            end else begin
                if (w_fetch_en) begin
                    r_pc <= r_pc + 32'd4;
                end
                case ({w_pop, w_fetch_en})
                    2'b01: begin
                        if (r_count == 2'd0) begin
                            r_head_pc   <= r_pc;
                            r_head_inst <= mem_data_out;
                        end else begin
                            r_tail_pc   <= r_pc;
                            r_tail_inst <= mem_data_out;
                        end
                        r_count <= r_count + 2'd1;
                    end
                    2'b10: begin
                        r_head_pc   <= r_tail_pc;
                        r_head_inst <= r_tail_inst;
                        r_tail_pc   <= 32'd0;
                        r_tail_inst <= 32'd0;
                        r_count     <= r_count - 2'd1;
                    end
                    2'b11: begin
                        if (r_count == 2'd1) begin
                            r_head_pc   <= r_pc;
                            r_head_inst <= mem_data_out;
                        end else begin
                            r_head_pc   <= r_tail_pc;
                            r_head_inst <= r_tail_inst;
                            r_tail_pc   <= r_pc;
                            r_tail_inst <= mem_data_out;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_fetch_en) begin
                $display("time=%t, address=%8h, data_out=%8h", $time, r_pc, mem_data_out);
            end
            if (w_fault_entry) begin
                $display("FETCH FAULT pc=%8h", r_pc);
            end
        end
    end
`else
    // Trace disabled: no simulation output, cycle behaviour unchanged.
`endif

    assign mem_address    = r_pc;
    assign mem_read_write = 1'b0;
    assign mem_data_in    = 32'd0;
    assign inst_valid     = (r_count != 2'd0);
    assign inst           = r_head_inst;
    assign inst_pc        = r_head_pc;
    assign fault          = r_fault;
    assign fault_pc       = r_fault_pc;

endmodule

`default_nettype wire
